// File: rtl/escalonador_temporizador.sv
// Round-robin scheduler that lends one modulo-M window timer to R requesters.
// Each grant lasts until the owner releases it or the count expires, which pulses expirou.
module escalonador_temporizador #(
  parameter int R = 4,
  parameter int M = 5000,
  parameter int N = 13
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [R-1:0] pedido,
  output logic [R-1:0] concessao,
  output logic         ocupado,
  output logic [N-1:0] Q,
  output logic [R-1:0] expirou,
  output logic         meio
);

  // state  | meaning
  // OCIOSO | no window active; pick next requester round-robin from ptr
  // CONTA  | window active for owner dono; Q counts 0..M-1
  // EXPIRA | one cycle after a full window; expirou pulses to the former owner

  localparam int W    = (R > 1) ? $clog2(R) : 1;
  localparam int MEIO = M / 2 - 1;

  typedef enum logic [1:0] {OCIOSO, CONTA, EXPIRA} estado_t;

  estado_t      estado, estado_n;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] dono, dono_n;
  logic [N-1:0] q_n;
  logic [R-1:0] conc_n, exp_n;
  logic         achou;
  logic [W-1:0] vencedor;

  // First set request bit at or after ptr, wrapping modulo R.
  always_comb begin
    int           idx;
    logic [W-1:0] cand;
    achou    = 1'b0;
    vencedor = ptr;
    idx      = 0;
    cand     = '0;
    for (int i = 0; i < R; i++) begin
      idx = int'(ptr) + i;
      if (idx >= R) idx = idx - R;
      cand = W'(idx);
      if (!achou && pedido[cand]) begin
        achou    = 1'b1;
        vencedor = cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      ptr       <= '0;
      dono      <= '0;
      Q         <= '0;
      concessao <= '0;
      expirou   <= '0;
    end else begin
      estado    <= estado_n;
      ptr       <= ptr_n;
      dono      <= dono_n;
      Q         <= q_n;
      concessao <= conc_n;
      expirou   <= exp_n;
    end
  end

  always_comb begin
    estado_n = estado;
    ptr_n    = ptr;
    dono_n   = dono;
    q_n      = '0;
    conc_n   = '0;
    exp_n    = '0;
    unique case (estado)
      OCIOSO: begin
        if (achou) begin
          estado_n         = CONTA;
          dono_n           = vencedor;
          conc_n[vencedor] = 1'b1;
          ptr_n            = (int'(vencedor) == R - 1) ? '0 : vencedor + W'(1);
        end
      end
      CONTA: begin
        // Release wins over expiry when both happen in the same cycle.
        if (!pedido[dono]) begin
          estado_n = OCIOSO;
        end else if (Q == N'(M - 1)) begin
          estado_n    = EXPIRA;
          exp_n[dono] = 1'b1;
        end else begin
          q_n          = Q + N'(1);
          conc_n[dono] = 1'b1;
        end
      end
      EXPIRA: estado_n = OCIOSO;
      default: estado_n = OCIOSO;
    endcase
  end

  assign ocupado = (estado == CONTA);
  assign meio    = ocupado && (Q == N'(MEIO));

endmodule
